// File: rtl/aes_decrypt.sv
// AES-128 byte-serial InvCipher: one shared S-box, on-the-fly inverse key schedule.
// Latency L = 391 clocks from the edge sampling en to the first output_ready cycle.
module aes_decrypt (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] input_data,
  input  logic [7:0] key,
  output logic [7:0] output_data,
  output logic [7:0] round_10,
  output logic       output_ready
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KEYEXP,
    DECRYPT,
    OUTPUT
  } state_t;

  state_t     st;
  logic [4:0] c;
  logic [3:0] ri;
  logic [7:0] rc;
  logic [7:0] s   [16];
  logic [7:0] k   [16];
  logic [7:0] r10 [16];

  logic       sb_inv;
  logic [7:0] sb_in;
  logic [7:0] sb_x;
  logic [7:0] sb_y;
  logic [7:0] sb_out;
  logic [1:0] kb;
  logic [1:0] kw;
  logic [3:0] sidx;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the field inverse, and maps 0 to 0 as the S-box needs
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] y;
    y = a;
    for (int i = 0; i < 6; i++) y = gmul(gmul(y, y), a);
    return gmul(y, y);
  endfunction

  function automatic logic [7:0] imc(
    input logic [7:0] a0,
    input logic [7:0] a1,
    input logic [7:0] a2,
    input logic [7:0] a3
  );
    return gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
         ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
  endfunction

  function automatic logic [3:0] isr(input int i);
    return 4'((i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4));
  endfunction

  always_comb begin
    kb     = c[1:0] + 2'd1;
    kw     = (st == KEYEXP) ? c[1:0] + 2'd2
                            : 2'd3 - c[1:0];
    sidx   = 4'(c - 5'd8);
    sb_inv = (st == DECRYPT) && (c >= 5'd8);
    sb_in  = sb_inv ? s[sidx] : k[{2'b11, kb + 2'd1}];
    sb_x   = sb_in;
    if (sb_inv)
      sb_x = {sb_in[6:0], sb_in[7]}
           ^ {sb_in[4:0], sb_in[7:5]}
           ^ {sb_in[1:0], sb_in[7:2]}
           ^ 8'h05;
    sb_y   = ginv(sb_x);
    sb_out = sb_y;
    if (!sb_inv)
      sb_out = sb_y
             ^ {sb_y[6:0], sb_y[7]}
             ^ {sb_y[5:0], sb_y[7:6]}
             ^ {sb_y[4:0], sb_y[7:5]}
             ^ {sb_y[3:0], sb_y[7:4]}
             ^ 8'h63;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      c  <= '0;
      ri <= '0;
      rc <= '0;
      for (int i = 0; i < 16; i++) begin
        s[i]   <= '0;
        k[i]   <= '0;
        r10[i] <= '0;
      end
      output_data  <= '0;
      round_10     <= '0;
      output_ready <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (en) begin
            st <= LOAD;
            c  <= '0;
          end
        end
        LOAD: begin
          if (c < 5'd16) s[c[3:0]] <= input_data;
          if (c >= 5'd12) k[4'(c - 5'd12)] <= key;
          if (c == 5'd27) begin
            st <= KEYEXP;
            c  <= 5'd3;
            ri <= '0;
            rc <= 8'h01;
          end else begin
            c <= c + 5'd1;
          end
        end
        KEYEXP: begin
          if (c <= 5'd6) begin
            k[{2'b00, kb}] <= k[{2'b00, kb}] ^ sb_out
                            ^ (kb == 2'd0 ? rc : 8'h00);
          end else begin
            for (int b = 0; b < 4; b++)
              k[{kw, 2'(b)}] <= k[{kw, 2'(b)}]
                              ^ k[{kw - 2'd1, 2'(b)}];
          end
          if (c == 5'd9) begin
            c <= 5'd3;
            if (ri == 4'd9) begin
              st <= DECRYPT;
              c  <= 5'd8;
              ri <= 4'd10;
            end else begin
              ri <= ri + 4'd1;
              rc <= xt(rc);
            end
          end else begin
            c <= c + 5'd1;
          end
        end
        DECRYPT: begin
          // round 10 enters at c=8, so it only does the AddRoundKey pass
          unique case (1'b1)
            (c <= 5'd2): begin
              for (int b = 0; b < 4; b++)
                k[{kw, 2'(b)}] <= k[{kw, 2'(b)}]
                                ^ k[{kw - 2'd1, 2'(b)}];
            end
            (c >= 5'd3 && c <= 5'd6): begin
              k[{2'b00, kb}] <= k[{2'b00, kb}] ^ sb_out
                              ^ (kb == 2'd0 ? rc : 8'h00);
              if (c == 5'd6)
                rc <= (rc == 8'h1b) ? 8'h80 : {1'b0, rc[7:1]};
            end
            (c == 5'd7): begin
              for (int i = 0; i < 16; i++)
                s[i] <= s[isr(i)];
            end
            (c >= 5'd8 && c <= 5'd23): begin
              s[sidx] <= (ri == 4'd10 ? s[sidx] : sb_out)
                       ^ k[sidx];
              if (ri == 4'd10 && c == 5'd8) r10 <= k;
            end
            default: begin
              for (int j = 0; j < 4; j++)
                s[{c[1:0], 2'(j)}] <= imc(
                  s[{c[1:0], 2'(j)}],
                  s[{c[1:0], 2'(j + 1)}],
                  s[{c[1:0], 2'(j + 2)}],
                  s[{c[1:0], 2'(j + 3)}]);
            end
          endcase
          if (c == 5'd27 ||
              (c == 5'd23 && (ri == 4'd0 || ri == 4'd10))) begin
            c  <= '0;
            ri <= ri - 4'd1;
            if (ri == 4'd0) begin
              st           <= OUTPUT;
              c            <= 5'd1;
              ri           <= '0;
              output_ready <= 1'b1;
              output_data  <= s[0];
              round_10     <= r10[0];
            end
          end else begin
            c <= c + 5'd1;
          end
        end
        OUTPUT: begin
          if (c == 5'd16) begin
            st           <= IDLE;
            c            <= '0;
            output_ready <= 1'b0;
          end else begin
            output_data <= s[c[3:0]];
            round_10    <= r10[c[3:0]];
            c           <= c + 5'd1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt.sv
// Bench for aes_decrypt: FIPS vectors, control corner cases and random
// blocks compared with a table-driven InvCipher model.
module tb_aes_decrypt;

  localparam int L = 391;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] input_data;
  logic [7:0] key;
  logic [7:0] output_data;
  logic [7:0] round_10;
  logic       output_ready;

  always #5 clk = ~clk;

  aes_decrypt dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .input_data(input_data),
    .key(key),
    .output_data(output_data),
    .round_10(round_10),
    .output_ready(output_ready)
  );

  typedef struct {
    logic [127:0] ct;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] r10;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  sb  [256];
  logic [7:0]  isb [256];
  logic [7:0]  rcon_t [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [31:0] imrow  [4]  = '{32'h0e0b0d09, 32'h090e0b0d,
                               32'h0d090e0b, 32'h0b0d090e};

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box by walking generator 3 and its inverse in parallel
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 1;
    q = 1;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
            ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'd1);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = i[7:0];
  endtask

  task automatic model(input logic [127:0] ct,
                       input logic [127:0] kin,
                       output logic [127:0] pt,
                       output logic [127:0] r10);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   b [16];
    logic [7:0]   tmp [16];
    logic [127:0] rk;
    for (int i = 0; i < 4; i++) w[i] = kin[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0)
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]}
          ^ {rcon_t[i/4-1], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    r10 = {w[40], w[41], w[42], w[43]};
    for (int i = 0; i < 16; i++)
      b[i] = ct[127-8*i -: 8] ^ r10[127-8*i -: 8];
    for (int r = 9; r >= 0; r--) begin
      rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      for (int i = 0; i < 16; i++)
        tmp[i] = isb[b[(i%4) + 4*(((i/4) - (i%4) + 4) % 4)]]
               ^ rk[127-8*i -: 8];
      for (int col = 0; col < 4; col++)
        for (int j = 0; j < 4; j++) begin
          if (r == 0) begin
            b[4*col+j] = tmp[4*col+j];
          end else begin
            b[4*col+j] = 0;
            for (int q = 0; q < 4; q++)
              b[4*col+j] ^= gm(tmp[4*col+q], imrow[j][31-8*q -: 8]);
          end
        end
    end
    for (int i = 0; i < 16; i++) pt[127-8*i -: 8] = b[i];
  endtask

  // fill: 0 zeros, 1 all-ones, 2 random outside the sampling windows
  task automatic run_block(input logic [127:0] ct,
                           input logic [127:0] kin,
                           input int fill, input bit spam,
                           input int abort_at, input int budget,
                           output logic [127:0] pt,
                           output logic [127:0] r10,
                           output int lat, output int nrdy);
    logic [7:0] f;
    pt = 0;
    r10 = 0;
    lat = -1;
    nrdy = 0;
    for (int n = 0; n < budget; n++) begin
      f = (fill == 1) ? 8'hff : (fill == 2) ? 8'($urandom) : 8'h00;
      en = (n == 0) || (n == abort_at) ||
           (spam && ((n % 7 == 3 && n < 380) || n == L + 15));
      rst = (n == abort_at);
      input_data = (n >= 1 && n <= 16) ? ct[127-8*(n-1) -: 8] : f;
      key = (n >= 13 && n <= 28) ? kin[127-8*(n-13) -: 8] : f;
      @(posedge clk);
      @(negedge clk);
      if (n == abort_at) begin
        check("rst_data", output_data, 0);
        check("rst_r10", round_10, 0);
        check("rst_ready", output_ready, 0);
      end
      if (output_ready) begin
        if (nrdy == 0) lat = n + 1;
        if (nrdy < 16) begin
          pt[127-8*nrdy -: 8] = output_data;
          r10[127-8*nrdy -: 8] = round_10;
        end
        nrdy++;
      end else if (nrdy > 0) begin
        break;
      end
    end
    en = 0;
    rst = 0;
  endtask

  task automatic idle_watch(input int cycles, output int highs);
    highs = 0;
    en = 0;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
      if (output_ready) highs++;
    end
  endtask

  vec_t         vt [2];
  logic [127:0] pt, r10, ept, er10, ct, kk;
  logic [127:0] pt2, r102;
  int           lat, lat2, nr, nr2, hi;

  initial begin
    build_sbox();
    vt[0].ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    vt[0].key = 128'h000102030405060708090a0b0c0d0e0f;
    vt[0].pt  = 128'h00112233445566778899aabbccddeeff;
    vt[0].r10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    vt[1].ct  = 128'h3925841d02dc09fbdc118597196a0b32;
    vt[1].key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vt[1].pt  = 128'h3243f6a8885a308d313198a2e0370734;
    vt[1].r10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst = 1;
    en = 0;
    input_data = 0;
    key = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_data", output_data, 0);
    check("reset_r10", round_10, 0);
    check("reset_ready", output_ready, 0);
    rst = 0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      run_block(vt[i].ct, vt[i].key, 0, 0, -1, 500,
                pt, r10, lat, nr);
      check("fips_pt", pt, vt[i].pt);
      check("fips_r10", r10, vt[i].r10);
      check("fips_lat", lat, L);
      check("fips_nrdy", nr, 16);
      repeat (3) @(negedge clk);
    end

    // back-to-back: second en on the first IDLE cycle
    run_block(vt[0].ct, vt[0].key, 2, 0, -1, 500, pt, r10, lat, nr);
    run_block(vt[1].ct, vt[1].key, 2, 0, -1, 500,
              pt2, r102, lat2, nr2);
    check("b2b_pt1", pt, vt[0].pt);
    check("b2b_pt2", pt2, vt[1].pt);
    check("b2b_r10_2", r102, vt[1].r10);
    check("b2b_lat_eq", lat2, lat);
    check("b2b_lat2", lat2, L);
    check("b2b_nrdy2", nr2, 16);

    // en spam while busy, including the last OUTPUT cycle
    run_block(vt[0].ct, vt[0].key, 0, 1, -1, 500, pt, r10, lat, nr);
    check("spam_pt", pt, vt[0].pt);
    check("spam_r10", r10, vt[0].r10);
    check("spam_lat", lat, L);
    check("spam_nrdy", nr, 16);
    idle_watch(420, hi);
    check("spam_no_restart", hi, 0);

    // abort during DECRYPT, en held with rst, then rerun
    run_block(vt[1].ct, vt[1].key, 0, 0, 200, 700, pt, r10, lat, nr);
    check("abort_nrdy", nr, 0);
    run_block(vt[1].ct, vt[1].key, 0, 0, -1, 500, pt, r10, lat, nr);
    check("after_abort_pt", pt, vt[1].pt);
    check("after_abort_r10", r10, vt[1].r10);
    check("after_abort_lat", lat, L);

    // windowing: ff outside the sampling windows
    repeat (2) @(negedge clk);
    run_block(vt[0].ct, vt[0].key, 1, 0, -1, 500, pt, r10, lat, nr);
    check("window_pt", pt, vt[0].pt);
    check("window_r10", r10, vt[0].r10);

    for (int t = 0; t < 8; t++) begin
      ct = {$urandom, $urandom, $urandom, $urandom};
      kk = {$urandom, $urandom, $urandom, $urandom};
      model(ct, kk, ept, er10);
      run_block(ct, kk, 2, 0, -1, 500, pt, r10, lat, nr);
      check("rnd_pt", pt, ept);
      check("rnd_r10", r10, er10);
      check("rnd_lat", lat, L);
      check("rnd_nrdy", nr, 16);
      if (t % 2 == 1) repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
